// File: rtl/cic3_comp_decim.sv
// Decimate the cic3 output by R, apply a 3-tap droop-compensation FIR, round/saturate
// to OUT_W and queue the samples in a small FIFO behind a valid/ready handshake.
module cic3_comp_decim #(
   parameter int IN_W       = 25,
   parameter int OUT_W      = 16,
   parameter int R          = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [IN_W-1:0]             cic_in,
   output logic [OUT_W-1:0]            dout,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int CNT_W = $clog2(R);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ACC_W = IN_W + 5;
   localparam int SHIFT = 3 + IN_W - OUT_W;

   localparam logic [CNT_W-1:0]        PHASE_LAST = CNT_W'(R - 1);
   localparam logic signed [ACC_W-1:0] RND        = ACC_W'(2 ** (SHIFT - 1));
   localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-(2 ** (OUT_W - 1)));
   localparam logic [PTR_W:0]          LVL_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]          LVL_ONE    = (PTR_W + 1)'(1);

   logic [CNT_W-1:0]        r_phase;
   logic                    w_strobe;
   logic signed [IN_W-1:0]  r_x0, r_x1, r_x2;
   logic                    r_fir_go;
   logic signed [ACC_W-1:0] w_x0e, w_x1e, w_x2e, w_acc, w_rnd, w_y;
   logic [OUT_W-1:0]        w_sat;
   logic [OUT_W-1:0]        r_result;
   logic                    r_push;

   logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr, w_rd_next;
   logic [PTR_W:0]          r_level;
   logic                    r_overflow;
   logic [OUT_W-1:0]        r_dout;
   logic                    w_pop, w_full, w_push_ok;

   assign w_strobe = (r_phase == PHASE_LAST);

   // acc = 10*x1 - x0 - x2; the extra 5 bits cover the worst-case gain of 12
   assign w_x0e = ACC_W'(r_x0);
   assign w_x1e = ACC_W'(r_x1);
   assign w_x2e = ACC_W'(r_x2);
   assign w_acc = (w_x1e <<< 3) + (w_x1e <<< 1) - w_x0e - w_x2e;
   assign w_rnd = w_acc + RND;
   assign w_y   = w_rnd >>> SHIFT;

   always_comb begin
      w_sat = w_y[OUT_W-1:0];
      if (w_y > SAT_MAX) begin
         w_sat = SAT_MAX[OUT_W-1:0];
      end else if (w_y < SAT_MIN) begin
         w_sat = SAT_MIN[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase  <= '0;
         r_x0     <= '0;
         r_x1     <= '0;
         r_x2     <= '0;
         r_fir_go <= 1'b0;
         r_result <= '0;
         r_push   <= 1'b0;
      end else begin
         r_phase  <= w_strobe ? '0 : r_phase + CNT_W'(1);
         r_fir_go <= w_strobe;
         r_push   <= r_fir_go;
         if (w_strobe) begin
            r_x2 <= r_x1;
            r_x1 <= r_x0;
            r_x0 <= cic_in;
         end
         if (r_fir_go) begin
            r_result <= w_sat;
         end
      end
   end

   // A pop in the same edge frees the slot, so a push into a full FIFO still lands
   assign w_full    = (r_level == LVL_FULL);
   assign w_pop     = (r_level != '0) && dout_ready;
   assign w_push_ok = r_push && (!w_full || w_pop);
   assign w_rd_next = r_rd_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_dout     <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_result;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         if (w_push_ok && !w_pop) begin
            r_level <= r_level + LVL_ONE;
         end else if (w_pop && !w_push_ok) begin
            r_level <= r_level - LVL_ONE;
         end
         if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         // dout is a register so it holds its last value once the FIFO drains
         if (w_pop) begin
            if (r_level > LVL_ONE) begin
               r_dout <= r_mem[w_rd_next];
            end else if (w_push_ok) begin
               r_dout <= r_result;
            end
         end else if (w_push_ok && (r_level == '0)) begin
            r_dout <= r_result;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = (r_level != '0);
   assign overflow   = r_overflow;
   assign level      = r_level;

endmodule

// File: doc/cic3_comp_decim.md
Name: cic3_comp_decim

Overview:
- Downstream stage for the cic3 integrator/comb output, running on the same modulator clock.
- Takes one cic3 output word every clock and decimates it by R using a free-running phase counter.
- Applies a 3-tap CIC droop-compensation FIR, then rounds and saturates the result to OUT_W.
- Buffers results in a small FIFO and presents them through a valid/ready handshake to the next consumer (register bank or serial link).

Parameters:
- IN_W, 25, width of the two's-complement input from cic3.
- OUT_W, 16, width of the two's-complement output sample; IN_W > OUT_W.
- R, 16, decimation ratio; must be >= 4.
- FIFO_DEPTH, 4, output FIFO entries; power of two.

Ports:
- clk  in  1  single clock, shared with modulator and cic3.
- reset  in  1  synchronous, active-high; one clock, synchronous, active-high reset (fixed).
- cic_in  in  IN_W  cic3 output word, sampled every clock, signed.
- dout  out  OUT_W  FIFO head sample, signed.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready at a rising edge.
- overflow  out  1  sticky: a decimated sample was dropped.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=1 at an edge) clears the following to 0:
  - phase counter
  - delay line x0/x1/x2
  - result register and push strobe
  - FIFO pointers and contents
  - dout, dout_valid, overflow, level
- Reset takes priority over all other activity, including an in-flight sample or pop; the in-flight sample is discarded.
- Phase counter: counts 0..R-1 and wraps. When counter==R-1, strobe s=1: x2<=x1, x1<=x0, x0<=cic_in. The first capture is the R-th clock after reset deasserts.
- FIR, evaluated in the cycle after s:
  - acc = 10*x1 - x0 - x2, computed in IN_W+5 bits signed; no internal overflow is possible.
  - DC gain is 8.
  - Scale: SHIFT = 3 + IN_W - OUT_W (12 at defaults).
  - y = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result register and push strobe are loaded at the edge one cycle after the capture edge.
- FIFO write happens on the following edge. Latency: capture edge t, result edge t+1, FIFO write edge t+2; dout_valid rises after edge t+2 if the FIFO was empty.
- The delay line is zero-primed, so the first two outputs after reset are transients and are not suppressed.
- Pop: on an edge with dout_valid && dout_ready, the head advances and dout shows the next entry (or holds its last value with dout_valid=0 when empty).
- dout is stable while dout_valid && !dout_ready.
- Full FIFO (level==FIFO_DEPTH) with a push and no pop in the same edge: the sample is dropped and overflow<=1. overflow stays set until reset.
- Simultaneous push and pop when full: the pop frees an entry, the push is accepted, level is unchanged, and no overflow occurs.
- Simultaneous push and pop when empty cannot occur, because dout_valid=0.
- Pointers wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.
- dout_ready is ignored while dout_valid=0.

Test Plan:
- DC step, dout_ready=1, cic_in=409600 constant from reset release: outputs -100, 900, 800, 800, ...; the first dout_valid appears exactly R+2 clocks after reset deasserts (first capture at R-1 clocks, plus 3 edges).
- Rounding, with x1=2048 and x0=x2=0 at the strobe: acc=20480, y=5; with acc=2048 exactly, y=1; with acc=-2048, y=0.
- Saturation, cic_in alternating +(2^24-1)/-(2^24-1) at each strobe: steady outputs clamp to 32767 and -32768, with no wrap-around sign flip.
- Backpressure: dout_ready=0 for 5 decimated samples → level=4, overflow=1 after the 5th write slot, 5th sample lost. Release dout_ready → the first 4 samples appear in order, level falls to 0, overflow stays 1.
- Full plus simultaneous pop: FIFO full, dout_ready pulsed high on the same edge as a push → level stays 4, overflow stays 0, ordering preserved.
- Reset mid-operation: assert reset one cycle after a strobe → the next edge clears dout_valid, level, overflow, delay line and phase. After release, the first new output again arrives R+2 clocks later with the primed sequence -100, 900, 800 for the DC input.
